// File: rtl/pixel_packer_if.sv
// Pixel stream into the packer and packed-word stream out to the DRAM writer.
// The slave modport is the packer's view; the master modport drives pixels and consumes words.
interface pixel_packer_if;
   logic [8:0]   h_count;
   logic [7:0]   v_count;
   logic         pixel_valid;
   logic         pixel_last;
   logic [15:0]  pixel_data;
   logic [127:0] word_data;
   logic [26:0]  word_addr;
   logic         word_valid;
   logic         word_ready;

   modport slave (
      input  h_count, v_count, pixel_valid, pixel_last, pixel_data, word_ready,
      output word_data, word_addr, word_valid
   );

   modport master (
      output h_count, v_count, pixel_valid, pixel_last, pixel_data, word_ready,
      input  word_data, word_addr, word_valid
   );
endinterface

// File: rtl/pixel_packer.sv
// Packs 320x180 RGB565 pixels eight to a 128-bit DRAM word, tracks raster order,
// and buffers completed words in a first-word-fall-through FIFO.
module pixel_packer #(
   parameter int          FIFO_DEPTH      = 16,
   parameter logic [26:0] FRAME_BASE_ADDR = 27'h0
) (
   input  logic                        clk,
   input  logic                        rst,
   pixel_packer_if.slave               bus,
   input  logic                        flags_clear,
   output logic                        frame_done,
   output logic                        overflow,
   output logic                        order_error,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam int          EW      = 128 + 27 + 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   localparam logic [0:0] EXPECT_FIRST = 1'b0;
   localparam logic [0:0] IN_FRAME     = 1'b1;

   logic         in_range;
   logic         acc;
   logic         mismatch;
   logic         order_set;
   logic         complete;
   logic [2:0]   lane;
   logic [26:0]  addr_calc;
   logic [127:0] pack_q;
   logic [127:0] pack_merge;
   logic [0:0]   state;
   logic [8:0]   exp_h;
   logic [7:0]   exp_v;

   logic         vld_p1;
   logic [127:0] cw_data_p1;
   logic [26:0]  cw_addr_p1;
   logic         cw_last_p1;

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [EW-1:0] head;
   logic          full;
   logic          pop;
   logic          push_ok;

   assign in_range  = (bus.h_count < 9'd320) && (bus.v_count < 8'd180);
   assign acc       = bus.pixel_valid && in_range;
   assign lane      = bus.h_count[2:0];
   assign mismatch  = (state == EXPECT_FIRST) ?
                      ((bus.h_count != 9'd0) || (bus.v_count != 8'd0)) :
                      ((bus.h_count != exp_h) || (bus.v_count != exp_v));
   assign order_set = bus.pixel_valid && (!in_range || mismatch);
   assign complete  = acc && ((lane == 3'd7) || bus.pixel_last);
   assign addr_calc = FRAME_BASE_ADDR + 27'(bus.v_count) * 27'd40 + 27'(bus.h_count[8:3]);

   always_comb begin
      pack_merge = pack_q;
      pack_merge[{lane, 4'b0000} +: 16] = bus.pixel_data;
   end

   // Order tracker: the expectation follows every packed pixel, so a skip is flagged once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EXPECT_FIRST;
         exp_h <= 9'd0;
         exp_v <= 8'd0;
      end else if (acc) begin
         if (bus.pixel_last) begin
            state <= EXPECT_FIRST;
            exp_h <= 9'd0;
            exp_v <= 8'd0;
         end else begin
            state <= IN_FRAME;
            if (bus.h_count == 9'd319) begin
               exp_h <= 9'd0;
               exp_v <= bus.v_count + 8'd1;
            end else begin
               exp_h <= bus.h_count + 9'd1;
               exp_v <= bus.v_count;
            end
         end
      end
   end

   // Stage p0 -> p1: pack register and completed-word holding register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pack_q <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= complete;
         if (acc) pack_q <= complete ? '0 : pack_merge;
      end
   end

   always_ff @(posedge clk) begin
      if (complete) begin
         cw_data_p1 <= pack_merge;
         cw_addr_p1 <= addr_calc;
         cw_last_p1 <= bus.pixel_last;
      end
   end

   // Stage p1 -> FIFO: entry layout is {data, addr, last}
   assign head           = mem[rd_ptr];
   assign bus.word_valid = (fifo_count != '0);
   assign full           = (fifo_count == DEPTH_C);
   assign pop            = bus.word_valid && bus.word_ready;
   assign push_ok        = vld_p1 && (!full || pop);
   assign bus.word_data  = bus.word_valid ? head[EW-1 -: 128] : '0;
   assign bus.word_addr  = bus.word_valid ? head[27:1] : '0;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {cw_data_p1, cw_addr_p1, cw_last_p1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         frame_done  <= 1'b0;
         overflow    <= 1'b0;
         order_error <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         frame_done <= pop && head[0];
         // Setting wins over a coincident clear
         if (vld_p1 && full && !pop) overflow <= 1'b1;
         else if (flags_clear)       overflow <= 1'b0;
         if (order_set)              order_error <= 1'b1;
         else if (flags_clear)       order_error <= 1'b0;
      end
   end
endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: number of packed-word entries in the output FIFO; power of two, at least 4.
REQ-002 Parameter FRAME_BASE_ADDR, default 27'h0: word address of pixel (0,0) in DRAM.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 h_count  input  9  column of the incoming pixel, 0..319.
REQ-006 v_count  input  8  row of the incoming pixel, 0..179.
REQ-007 pixel_valid  input  1  pixel beat present this cycle; no backpressure upstream.
REQ-008 pixel_last  input  1  qualifies the final pixel (319,179) of a frame.
REQ-009 pixel_data  input  16  RGB565 colour.
REQ-010 flags_clear  input  1  one-cycle pulse that clears the sticky error flags.
REQ-011 word_data  output  128  eight packed pixels; lane k occupies bits [16k+15:16k].
REQ-012 word_addr  output  27  DRAM word address of word_data.
REQ-013 word_valid  output  1  FIFO head valid.
REQ-014 word_ready  input  1  downstream accepts the head when it is high together with word_valid.
REQ-015 frame_done  output  1  one-cycle pulse when the word holding the last pixel is accepted.
REQ-016 overflow  output  1  sticky; a completed word was dropped because the FIFO was full.
REQ-017 order_error  output  1  sticky; a pixel arrived out of raster order or out of range.
REQ-018 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-019 An accepted pixel SHALL be written into lane h_count[2:0] of the pack register.
REQ-020 The pack register SHALL complete when the accepted pixel has lane 7 or pixel_last is high.
REQ-021 A completed word SHALL carry address FRAME_BASE_ADDR + v_count*40 + h_count[8:3] and a last tag equal to pixel_last.
REQ-022 Lanes of a completed word that were not written since the previous completion SHALL be zero.
REQ-023 The pack register SHALL clear after completion.
REQ-024 A completed word SHALL be pushed into the FIFO on the edge after the edge that sampled its completing pixel.
REQ-025 With the FIFO empty, word_valid SHALL rise two edges after the completing pixel is sampled.
REQ-026 Order tracker states: EXPECT_FIRST (expected pixel (0,0)) and IN_FRAME (expected pixel = previous plus one in raster order).
REQ-027 The tracker SHALL move EXPECT_FIRST to IN_FRAME on any accepted pixel.
REQ-028 The tracker SHALL return to EXPECT_FIRST after a pixel with pixel_last.
REQ-029 A coordinate mismatch SHALL set order_error; the pixel is still packed at its own coordinates and the expectation resynchronises to it.
REQ-030 A pixel with h_count≥320 or v_count≥180 SHALL be dropped (not packed, no completion) and SHALL set order_error.
REQ-031 The FIFO SHALL be first-word-fall-through: word_valid = not empty, and word_data/word_addr are held stable while word_valid is high and word_ready is low.
REQ-032 A pop SHALL occur when word_valid and word_ready are both high.
REQ-033 A push to a full FIFO SHALL succeed if a pop occurs in the same cycle.
REQ-034 A push to a full FIFO with no pop SHALL drop the word and set overflow.
REQ-035 fifo_count SHALL track pushes and pops; a simultaneous push and pop leaves it unchanged.
REQ-036 frame_done SHALL pulse for exactly one cycle, the cycle after the pop of a last-tagged word.
REQ-037 flags_clear SHALL clear overflow and order_error on the next edge.
REQ-038 A set condition in the same cycle as flags_clear SHALL take priority, leaving the flag set.

Reset
REQ-039 While rst is high, and asynchronously on its assertion, the block SHALL empty the FIFO, clear the pack register, and enter EXPECT_FIRST.
REQ-040 Reset values: word_valid=0, word_data=0, word_addr=0, frame_done=0, overflow=0, order_error=0, fifo_count=0.
REQ-041 Reset mid-frame SHALL discard all buffered words; the next frame restarts at (0,0) with no error flagged.

Verification
REQ-042 Stream a full 320x180 frame with word_ready=1: expect 7200 words, addresses 0..7199, word 0 = pixels 0..7 in lanes 0..7, one frame_done pulse, both flags 0.
REQ-043 Hold word_ready=0 for 8 pixels (h 0..7, v 0): word_valid rises two edges after pixel 7 is sampled, data is held stable, fifo_count=1; raise ready and the word pops.
REQ-044 Hold word_ready=0 for 17 full words with FIFO_DEPTH=16: fifo_count=16, overflow=1, the first 16 words are intact, the 17th is lost.
REQ-045 Send (0,0) then (5,0): order_error=1; the word at address 0 has lanes 0 and 5 set once completed; flags_clear returns order_error to 0.
REQ-046 Send h_count=400: pixel dropped, order_error=1, fifo_count unchanged.
REQ-047 Assert rst after 100 pixels with 3 words queued: fifo_count=0 and word_valid=0 immediately; a following full frame passes as in REQ-042.
